// File: rtl/systolic_mem_pkg.sv
// rtl/systolic_mem_pkg.sv - shared enums for the systolic memory sequencer
// Purpose: operation mode encoding and sequencer FSM state encoding.
// Ports: none (package).
package systolic_mem_pkg;

  // Encoding matches the 2-bit mode input.
  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_AS   = 2'd1,
    MODE_SA   = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STREAM = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_SAVE   = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/seq_addr_gen.sv
// rtl/seq_addr_gen.sv - base/stride address arithmetic for the sequencer
// Purpose: forms the A-RAM operand address, the S-RAM operand address and the
//          S-RAM result-row address from the sequencer counters. All math is
//          done at AW width and wraps modulo 2^AW.
// Ports:
//   line   in  LW  current line within the block
//   k      in  KW  current k-step within the line
//   blk    in  BW  current result block
//   row    in  KW  save row index t (0 = first written)
//   a_addr out AW  BASE_A + line*A_STR_L + k*A_STR_K
//   s_addr out AW  BASE_S + blk*S_STR_B + line*S_STR_L + k*S_STR_K
//   r_addr out AW  BASE_R + blk*R_STR_B + (TILE-1-row)*R_STR_T
module seq_addr_gen #(
  parameter int AW   = 32,
  parameter int TILE = 4,
  parameter int LW   = 2,
  parameter int KW   = 2,
  parameter int BW   = 2,
  parameter logic [AW-1:0] BASE_A  = '0,
  parameter logic [AW-1:0] A_STR_L = '0,
  parameter logic [AW-1:0] A_STR_K = '0,
  parameter logic [AW-1:0] BASE_S  = '0,
  parameter logic [AW-1:0] S_STR_B = '0,
  parameter logic [AW-1:0] S_STR_L = '0,
  parameter logic [AW-1:0] S_STR_K = '0,
  parameter logic [AW-1:0] BASE_R  = '0,
  parameter logic [AW-1:0] R_STR_B = '0,
  parameter logic [AW-1:0] R_STR_T = '0
) (
  input  logic [LW-1:0] line,
  input  logic [KW-1:0] k,
  input  logic [BW-1:0] blk,
  input  logic [KW-1:0] row,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] s_addr,
  output logic [AW-1:0] r_addr
);

  logic [AW-1:0] line_w;
  logic [AW-1:0] k_w;
  logic [AW-1:0] blk_w;
  logic [AW-1:0] rrow_w;

  assign line_w = AW'(line);
  assign k_w    = AW'(k);
  assign blk_w  = AW'(blk);
  // Rows are stored bottom-up: the first row saved lands at the highest slot.
  assign rrow_w = AW'(TILE - 1) - AW'(row);

  assign a_addr = BASE_A + line_w * A_STR_L + k_w * A_STR_K;
  assign s_addr = BASE_S + blk_w * S_STR_B + line_w * S_STR_L + k_w * S_STR_K;
  assign r_addr = BASE_R + blk_w * R_STR_B + rrow_w * R_STR_T;

endmodule

// File: rtl/systolic_mem_seq.sv
// rtl/systolic_mem_seq.sv - operand streaming / result save sequencer for a systolic tile
// Purpose: streams LINES*TILE operand beats from the A and S RAMs into the
//          array, waits DRAIN cycles, saves TILE result rows into the S RAM,
//          and repeats for BLOCKS result blocks.
// Optional feature: define SYSMEM_ACCUM_EN to make each saved row a
//          read-modify-write (rd_data_s + acc_in) taking 2 cycles per row.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start, mode, abort command inputs (mode 1 AS, 2 SA, 3 reserved)
//   rd_data_a/s        RAM read data, 1-cycle latency
//   addr_a, addr_s     RAM addresses; wen_s/wdata_s S-RAM write port
//   data_left/right    array operands; acc_in array result for the save row
//   tp_sel, sys_en, sys_mode, busy, done, err  status/control outputs
// DRAIN must be at least 1.
module systolic_mem_seq
  import systolic_mem_pkg::*;
#(
  parameter int DW     = 64,
  parameter int AW     = 32,
  parameter int TILE   = 4,
  parameter int LINES  = 336,
  parameter int BLOCKS = 2,
  parameter int DRAIN  = 8,
  parameter logic [AW-1:0] BASE_A  = '0,
  parameter logic [AW-1:0] A_STR_L = AW'(TILE),
  parameter logic [AW-1:0] A_STR_K = AW'(1),
  parameter logic [AW-1:0] BASE_S  = '0,
  parameter logic [AW-1:0] S_STR_B = AW'(LINES * TILE),
  parameter logic [AW-1:0] S_STR_L = AW'(TILE),
  parameter logic [AW-1:0] S_STR_K = AW'(1),
  parameter logic [AW-1:0] BASE_R  = '0,
  parameter logic [AW-1:0] R_STR_B = AW'(TILE),
  parameter logic [AW-1:0] R_STR_T = AW'(1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic          abort,
  input  logic [DW-1:0] rd_data_a,
  input  logic [DW-1:0] rd_data_s,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_s,
  output logic          wen_s,
  output logic [DW-1:0] wdata_s,
  output logic [DW-1:0] data_left,
  output logic [DW-1:0] data_right,
  input  logic [DW-1:0] acc_in,
  output logic          tp_sel,
  output logic          sys_en,
  output logic          sys_mode,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int KW = $clog2(TILE);
  localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
  // blk is incremented in NEXT of the last block, so it must hold BLOCKS.
  localparam int BW = $clog2(BLOCKS + 1);
`ifdef SYSMEM_ACCUM_EN
  localparam int SAVE_LEN = 2 * TILE;
`else
  localparam int SAVE_LEN = TILE;
`endif
  localparam int SMAX = (DRAIN > SAVE_LEN) ? DRAIN : SAVE_LEN;
  localparam int SW = $clog2(SMAX + 1);

  state_e        state;
  mode_e         mode_q;
  logic [KW-1:0] cnt_k;
  logic [LW-1:0] cnt_line;
  logic [BW-1:0] blk;
  logic [SW-1:0] cnt_s;      // shared DRAIN / SAVE cycle counter
  logic          d_vld;      // an operand address was issued last cycle

  logic [KW-1:0] save_row;
  logic          save_wr;
  logic [DW-1:0] save_data;
  logic [AW-1:0] a_addr;
  logic [AW-1:0] s_addr;
  logic [AW-1:0] r_addr;

`ifdef SYSMEM_ACCUM_EN
  // Even cycle reads the row, odd cycle writes the accumulated value back.
  assign save_row  = cnt_s[KW:1];
  assign save_wr   = cnt_s[0];
  assign save_data = rd_data_s + acc_in;
`else
  assign save_row  = cnt_s[KW-1:0];
  assign save_wr   = 1'b1;
  assign save_data = acc_in;
`endif

  seq_addr_gen #(
    .AW(AW), .TILE(TILE), .LW(LW), .KW(KW), .BW(BW),
    .BASE_A(BASE_A), .A_STR_L(A_STR_L), .A_STR_K(A_STR_K),
    .BASE_S(BASE_S), .S_STR_B(S_STR_B), .S_STR_L(S_STR_L), .S_STR_K(S_STR_K),
    .BASE_R(BASE_R), .R_STR_B(R_STR_B), .R_STR_T(R_STR_T)
  ) u_addr_gen (
    .line   (cnt_line),
    .k      (cnt_k),
    .blk    (blk),
    .row    (save_row),
    .a_addr (a_addr),
    .s_addr (s_addr),
    .r_addr (r_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      mode_q   <= MODE_IDLE;
      cnt_k    <= '0;
      cnt_line <= '0;
      blk      <= '0;
      cnt_s    <= '0;
      d_vld    <= 1'b0;
      tp_sel   <= 1'b1;
      err      <= 1'b0;
    end else begin
      err   <= 1'b0;
      d_vld <= 1'b0;
      if (abort) begin
        state    <= ST_IDLE;
        mode_q   <= MODE_IDLE;
        cnt_k    <= '0;
        cnt_line <= '0;
        blk      <= '0;
        cnt_s    <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (mode == MODE_AS || mode == MODE_SA) begin
                mode_q   <= mode_e'(mode);
                state    <= ST_STREAM;
                cnt_k    <= '0;
                cnt_line <= '0;
                blk      <= '0;
                cnt_s    <= '0;
              end else if (mode == MODE_RSVD) begin
                err <= 1'b1;
              end
            end
          end
          ST_STREAM: begin
            d_vld <= 1'b1;
            if (cnt_k == '0) tp_sel <= ~tp_sel;
            if (cnt_k == KW'(TILE - 1)) begin
              cnt_k <= '0;
              if (cnt_line == LW'(LINES - 1)) begin
                cnt_line <= '0;
                cnt_s    <= '0;
                state    <= ST_DRAIN;
              end else begin
                cnt_line <= cnt_line + LW'(1);
              end
            end else begin
              cnt_k <= cnt_k + KW'(1);
            end
          end
          ST_DRAIN: begin
            if (cnt_s == SW'(DRAIN - 1)) begin
              cnt_s <= '0;
              state <= ST_SAVE;
            end else begin
              cnt_s <= cnt_s + SW'(1);
            end
          end
          ST_SAVE: begin
            if (cnt_s == SW'(SAVE_LEN - 1)) begin
              cnt_s <= '0;
              state <= ST_NEXT;
            end else begin
              cnt_s <= cnt_s + SW'(1);
            end
          end
          ST_NEXT: begin
            blk      <= blk + BW'(1);
            cnt_k    <= '0;
            cnt_line <= '0;
            state    <= (blk < BW'(BLOCKS - 1)) ? ST_STREAM : ST_DONE;
          end
          ST_DONE: begin
            state  <= ST_IDLE;
            mode_q <= MODE_IDLE;
            blk    <= '0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign sys_mode = (mode_q == MODE_AS);
  // Data beats run one cycle behind the addresses and the array keeps
  // computing through the drain window.
  assign sys_en   = d_vld | (state == ST_DRAIN);

  assign addr_a = (state == ST_STREAM) ? a_addr :
                  '0;
  assign addr_s = (state == ST_STREAM) ? s_addr :
                  (state == ST_SAVE)   ? r_addr :
                  '0;

  // abort is combinational here so the write is suppressed in the abort cycle.
  assign wen_s   = (state == ST_SAVE) && save_wr && !abort;
  assign wdata_s = wen_s ? save_data : '0;

  assign data_left  = !d_vld ? '0 : (mode_q == MODE_AS) ? rd_data_a : rd_data_s;
  assign data_right = !d_vld ? '0 : (mode_q == MODE_AS) ? rd_data_s : rd_data_a;

endmodule

// File: tb/tb_systolic_mem_seq.sv
// tb/tb_systolic_mem_seq.sv - scoreboard bench for systolic_mem_seq
module tb_systolic_mem_seq;

  localparam int DW = 64, AW = 32, TILE = 4, LINES = 3, BLOCKS = 2, DRAIN = 3;
  localparam logic [31:0] BASE_A  = 32'h0000_0100, A_STR_L = 32'h10, A_STR_K = 32'h1;
  localparam logic [31:0] BASE_S  = 32'hFFFF_FFF0, S_STR_B = 32'h8, S_STR_L = 32'h10, S_STR_K = 32'h4;
  localparam logic [31:0] BASE_R  = 32'h0000_2000, R_STR_B = 32'h40, R_STR_T = 32'h4;

  logic          clk, rst, start, abort;
  logic [1:0]    mode;
  logic [DW-1:0] rd_data_a, rd_data_s, acc_in;
  logic [AW-1:0] addr_a, addr_s;
  logic          wen_s;
  logic [DW-1:0] wdata_s, data_left, data_right;
  logic          tp_sel, sys_en, sys_mode, busy, done, err;

  systolic_mem_seq #(
    .DW(DW), .AW(AW), .TILE(TILE), .LINES(LINES), .BLOCKS(BLOCKS), .DRAIN(DRAIN),
    .BASE_A(BASE_A), .A_STR_L(A_STR_L), .A_STR_K(A_STR_K),
    .BASE_S(BASE_S), .S_STR_B(S_STR_B), .S_STR_L(S_STR_L), .S_STR_K(S_STR_K),
    .BASE_R(BASE_R), .R_STR_B(R_STR_B), .R_STR_T(R_STR_T)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .rd_data_a(rd_data_a), .rd_data_s(rd_data_s),
    .addr_a(addr_a), .addr_s(addr_s), .wen_s(wen_s), .wdata_s(wdata_s),
    .data_left(data_left), .data_right(data_right), .acc_in(acc_in),
    .tp_sel(tp_sel), .sys_en(sys_en), .sys_mode(sys_mode),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] salt;

  // RAM contents are a function of the address so every beat identifies the
  // address that produced it; the upper word is never zero.
  function automatic logic [63:0] fa(input logic [31:0] a, input logic [31:0] s);
    return {s | 32'h8000_0000, a};
  endfunction
  function automatic logic [63:0] fs(input logic [31:0] a, input logic [31:0] s);
    return {((s >> 1) | 32'h4000_0000) & 32'h7FFF_FFFF, a};
  endfunction
  function automatic logic [63:0] fc(input logic [31:0] a, input logic [31:0] s);
    return {s, ~a};
  endfunction

  always @(posedge clk) begin
    rd_data_a <= fa(addr_a, salt);
    rd_data_s <= fs(addr_s, salt);
  end
  assign acc_in = fc(addr_s, salt);

  typedef struct { logic [63:0] left; logic [63:0] right; logic smode; } beat_t;
  typedef struct { logic [31:0] addr; logic [63:0] data; } wr_t;
  beat_t beat_q[$];
  wr_t   wr_q[$];

  int   tests = 0, fails = 0;
  int   done_cnt = 0, err_cnt = 0, tog_cnt = 0;
  bit   mon_en = 0;
  logic prev_tp = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    beat_t b;
    wr_t   w;
    forever begin
      @(negedge clk);
      #2;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (tp_sel !== prev_tp) tog_cnt++;
      prev_tp = tp_sel;
      if (mon_en) begin
        if (data_left != 0 || data_right != 0) begin
          if (beat_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL beat_extra: got left %h right %h, no beat expected", data_left, data_right);
          end else begin
            b = beat_q.pop_front();
            check("data_left", data_left, b.left);
            check("data_right", data_right, b.right);
            check("sys_mode", 64'(sys_mode), 64'(b.smode));
            check("sys_en_beat", 64'(sys_en), 64'd1);
          end
        end
        if (wen_s) begin
          if (wr_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL write_extra: got addr %h data %h, no write expected", addr_s, wdata_s);
          end else begin
            w = wr_q.pop_front();
            check("write_addr", 64'(addr_s), 64'(w.addr));
            check("write_data", wdata_s, w.data);
          end
        end else begin
          check("wdata_idle", wdata_s, 64'd0);
        end
      end
    end
  endtask

  task automatic run_op(input logic [1:0] m);
    logic [31:0] a, s, r;
    beat_t bt;
    wr_t   wt;
    bit    got_done;
    int    cyc;
    salt = $urandom;
    for (int b = 0; b < BLOCKS; b++) begin
      for (int l = 0; l < LINES; l++) begin
        for (int k = 0; k < TILE; k++) begin
          a = BASE_A + 32'(l) * A_STR_L + 32'(k) * A_STR_K;
          s = BASE_S + 32'(b) * S_STR_B + 32'(l) * S_STR_L + 32'(k) * S_STR_K;
          bt.left  = (m == 2'd1) ? fa(a, salt) : fs(s, salt);
          bt.right = (m == 2'd1) ? fs(s, salt) : fa(a, salt);
          bt.smode = (m == 2'd1);
          beat_q.push_back(bt);
        end
      end
      for (int t = 0; t < TILE; t++) begin
        r = BASE_R + 32'(b) * R_STR_B + 32'(TILE - 1 - t) * R_STR_T;
        wt.addr = r;
`ifdef SYSMEM_ACCUM_EN
        wt.data = fs(r, salt) + fc(r, salt);
`else
        wt.data = fc(r, salt);
`endif
        wr_q.push_back(wt);
      end
    end
    done_cnt = 0; err_cnt = 0; tog_cnt = 0;
    @(negedge clk); start = 1'b1; mode = m;
    @(negedge clk); start = 1'b0; mode = 2'd0;
    #2 check("busy_run", 64'(busy), 64'd1);
    got_done = 0;
    cyc = 0;
    while (!got_done && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      // a start issued while busy must be ignored, reserved mode included
      if (cyc == 7) begin start = 1'b1; mode = 2'($urandom_range(1, 3)); end
      else begin start = 1'b0; mode = 2'd0; end
      #2 if (done) got_done = 1;
    end
    start = 1'b0;
    check("done_seen", 64'(got_done), 64'd1);
    @(negedge clk);
    #3;
    check("beats_left", 64'(beat_q.size()), 64'd0);
    check("writes_left", 64'(wr_q.size()), 64'd0);
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("err_pulses", 64'(err_cnt), 64'd0);
    check("tp_toggles", 64'(tog_cnt), 64'(BLOCKS * LINES));
    check("busy_after", 64'(busy), 64'd0);
    beat_q.delete();
    wr_q.delete();
  endtask

  initial begin
    bit found;
    rst = 1'b1; start = 1'b0; mode = 2'd0; abort = 1'b0; salt = 32'h1;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_wen", 64'(wen_s), 64'd0);
    check("rst_addr_a", 64'(addr_a), 64'd0);
    check("rst_addr_s", 64'(addr_s), 64'd0);
    check("rst_sys_en", 64'(sys_en), 64'd0);
    check("rst_sys_mode", 64'(sys_mode), 64'd0);
    check("rst_tp_sel", 64'(tp_sel), 64'd1);
    check("rst_left", data_left, 64'd0);
    check("rst_wdata", wdata_s, 64'd0);
    @(negedge clk); rst = 1'b0;
    mon_en = 1;

    run_op(2'd1);
    run_op(2'd2);
    for (int i = 0; i < 4; i++) run_op(2'($urandom_range(1, 2)));

    // mode 0 start is ignored
    err_cnt = 0;
    @(negedge clk); start = 1'b1; mode = 2'd0;
    @(negedge clk); start = 1'b0;
    #2 check("mode0_busy", 64'(busy), 64'd0);

    // reserved mode: one err pulse, stays idle
    @(negedge clk); start = 1'b1; mode = 2'd3;
    @(negedge clk); start = 1'b0; mode = 2'd0;
    #2 check("rsvd_err", 64'(err), 64'd1);
    check("rsvd_busy", 64'(busy), 64'd0);
    @(negedge clk);
    #3 check("rsvd_err_clear", 64'(err), 64'd0);
    check("rsvd_busy2", 64'(busy), 64'd0);
    check("rsvd_err_pulses", 64'(err_cnt), 64'd1);

    // abort and start together resolve to abort
    @(negedge clk); start = 1'b1; mode = 2'd1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    #2 check("abort_start_busy", 64'(busy), 64'd0);

    // abort in a SAVE write cycle
    mon_en = 0;
    done_cnt = 0;
    @(negedge clk); start = 1'b1; mode = 2'd2;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      #2 if (wen_s) found = 1;
    end
    check("save_reached", 64'(found), 64'd1);
    abort = 1'b1;
    #1 check("abort_wen", 64'(wen_s), 64'd0);
    check("abort_busy_same", 64'(busy), 64'd1);
    @(negedge clk); abort = 1'b0;
    #2 check("abort_idle", 64'(busy), 64'd0);
    check("abort_addr_s", 64'(addr_s), 64'd0);
    repeat (60) @(negedge clk);
    #3 check("abort_no_done", 64'(done_cnt), 64'd0);

    // asynchronous reset mid-operation
    @(negedge clk); start = 1'b1; mode = 2'd1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("arst_busy", 64'(busy), 64'd0);
    check("arst_sys_en", 64'(sys_en), 64'd0);
    check("arst_tp_sel", 64'(tp_sel), 64'd1);
    check("arst_addr_a", 64'(addr_a), 64'd0);
    @(negedge clk); rst = 1'b0;
    repeat (60) @(negedge clk);
    #3 check("arst_no_resume", 64'(busy), 64'd0);
    check("arst_no_done", 64'(done_cnt), 64'd0);

    beat_q.delete();
    wr_q.delete();
    mon_en = 1;
    run_op(2'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
